// File: rtl/spi_slave_gen2.sv
// SPI slave: deserialises {opcode, payload} frames from MOSI and returns RAM read data on MISO.
// One SPI bit per clk; SS_n low delimits a frame, and deselecting mid-frame raises frame_err.
module spi_slave_gen2 #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  output logic              MISO,
  output logic              frame_err,
  output logic              busy
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int WAIT_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHK_CMD,
    S_WRITE,
    S_READ_ADD,
    S_READ_DATA_RX,
    S_READ_WAIT,
    S_READ_TX,
    S_DONE
  } state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [WAIT_W-1:0]  r_wait_cnt, w_wait_cnt_next;
  logic [FRAME_W-1:0] r_rx_data, w_rx_data_next;
  logic [DATA_W-1:0]  r_tx_shift, w_tx_shift_next;
  logic               r_rx_valid, w_rx_valid_next;
  logic               r_miso, w_miso_next;
  logic               r_frame_err, w_frame_err_next;
  logic               r_rd_addr_seen, w_rd_addr_seen_next;
  logic [FRAME_W-1:0] w_bit_sel;
  logic               w_frame_open;
  logic               w_wait_expired;

  // One-hot select of the rx_data bit addressed by the down-counter (bit cnt-1).
  generate
    for (genvar gi = 0; gi < FRAME_W; gi++) begin : g_bit_sel
      assign w_bit_sel[gi] = (r_cnt == CNT_W'(gi + 1));
    end
  endgenerate

  assign w_frame_open   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_wait_expired = (r_wait_cnt == WAIT_W'(TX_TIMEOUT - 1));

  always_comb begin
    w_state_next        = r_state;
    w_cnt_next          = r_cnt;
    w_wait_cnt_next     = r_wait_cnt;
    w_rx_data_next      = r_rx_data;
    w_tx_shift_next     = r_tx_shift;
    w_rx_valid_next     = 1'b0;
    w_miso_next         = 1'b0;
    w_frame_err_next    = 1'b0;
    w_rd_addr_seen_next = r_rd_addr_seen;

    if ((r_state != S_IDLE) && SS_n) begin
      // Deselect always wins; only an unfinished frame is reported as an error.
      w_state_next     = S_IDLE;
      w_frame_err_next = w_frame_open;
      w_cnt_next       = '0;
      w_wait_cnt_next  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!SS_n) w_state_next = S_CHK_CMD;
        end
        S_CHK_CMD: begin
          w_cnt_next      = CNT_W'(FRAME_W);
          w_wait_cnt_next = '0;
          if (!MOSI)               w_state_next = S_WRITE;
          else if (r_rd_addr_seen) w_state_next = S_READ_DATA_RX;
          else                     w_state_next = S_READ_ADD;
        end
        S_WRITE, S_READ_ADD, S_READ_DATA_RX: begin
          if (r_cnt != '0) begin
            w_rx_data_next = (r_rx_data & ~w_bit_sel) | (w_bit_sel & {FRAME_W{MOSI}});
            w_cnt_next     = r_cnt - CNT_W'(1);
          end else begin
            w_rx_valid_next = 1'b1;
            if (r_state == S_READ_DATA_RX) begin
              w_state_next = S_READ_WAIT;
            end else begin
              w_state_next = S_DONE;
              if (r_state == S_READ_ADD) w_rd_addr_seen_next = 1'b1;
            end
          end
        end
        S_READ_WAIT: begin
          if (tx_valid) begin
            w_tx_shift_next = tx_data;
            w_cnt_next      = CNT_W'(DATA_W);
            w_state_next    = S_READ_TX;
          end else if (w_wait_expired) begin
            w_frame_err_next    = 1'b1;
            w_rd_addr_seen_next = 1'b0;
            w_state_next        = S_DONE;
          end else begin
            w_wait_cnt_next = r_wait_cnt + WAIT_W'(1);
          end
        end
        S_READ_TX: begin
          if (r_cnt != '0) begin
            w_miso_next     = r_tx_shift[DATA_W-1];
            w_tx_shift_next = r_tx_shift << 1;
            w_cnt_next      = r_cnt - CNT_W'(1);
          end else begin
            w_rd_addr_seen_next = 1'b0;
            w_state_next        = S_DONE;
          end
        end
        S_DONE: begin
          w_state_next = S_DONE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_wait_cnt     <= '0;
      r_rx_data      <= '0;
      r_tx_shift     <= '0;
      r_rx_valid     <= 1'b0;
      r_miso         <= 1'b0;
      r_frame_err    <= 1'b0;
      r_rd_addr_seen <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_cnt          <= w_cnt_next;
      r_wait_cnt     <= w_wait_cnt_next;
      r_rx_data      <= w_rx_data_next;
      r_tx_shift     <= w_tx_shift_next;
      r_rx_valid     <= w_rx_valid_next;
      r_miso         <= w_miso_next;
      r_frame_err    <= w_frame_err_next;
      r_rd_addr_seen <= w_rd_addr_seen_next;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign MISO      = r_miso;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_slave_gen2.sv
// Bench for spi_slave_gen2: frames are planned from the protocol timing rules, driven bit by bit,
// and every cycle's outputs are compared with the planned expectation.
module tb_spi_slave_gen2;

  localparam int DW   = 8;
  localparam int FW   = DW + 2;
  localparam int TO   = 16;
  localparam int DW2  = 12;
  localparam int FW2  = DW2 + 2;
  localparam int MAXE = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          ss_n, mosi, tx_valid;
  logic [DW-1:0] tx_data;
  logic [FW-1:0] rx_data;
  logic          rx_valid, miso, frame_err, busy;

  logic           ss_n_w, mosi_w, tx_valid_w;
  logic [DW2-1:0] tx_data_w;
  logic [FW2-1:0] rx_data_w;
  logic           rx_valid_w, miso_w, frame_err_w, busy_w;

  spi_slave_gen2 #(.DATA_W(DW), .TX_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .tx_data(tx_data), .tx_valid(tx_valid),
    .rx_data(rx_data), .rx_valid(rx_valid), .MISO(miso), .frame_err(frame_err), .busy(busy)
  );

  spi_slave_gen2 #(.DATA_W(DW2), .TX_TIMEOUT(5)) dut_wide (
    .clk(clk), .rst(rst), .SS_n(ss_n_w), .MOSI(mosi_w), .tx_data(tx_data_w), .tx_valid(tx_valid_w),
    .rx_data(rx_data_w), .rx_valid(rx_valid_w), .MISO(miso_w), .frame_err(frame_err_w), .busy(busy_w)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Planned frame: stimulus per edge and expected {rx_valid, frame_err, MISO, busy} after each edge.
  bit            mosi_a [MAXE];
  bit            txv_a  [MAXE];
  logic [3:0]    exp_v  [MAXE];
  logic [3:0]    obs_v  [MAXE];
  logic [FW-1:0] obs_rxd[MAXE];
  logic [FW-1:0] exp_rxd;
  logic [DW-1:0] exp_txd;
  int            m_tcap;
  int            m_n;
  bit            m_seen;

  // kind: 0 write, 1 read-address, 2 read-data. n = number of edges with SS_n low.
  // d = delay of tx_valid after the first sampling edge; d >= TO means it never arrives.
  task automatic plan_frame(input bit cmd, input logic [FW-1:0] pay, input int n, input int d,
                            input logic [DW-1:0] txd);
    int kind, t, done_e;
    bit tmo, b_rxv, b_err, b_miso;
    kind   = !cmd ? 0 : (m_seen ? 2 : 1);
    t      = DW + 5 + d;
    tmo    = (d >= TO);
    done_e = (kind != 2) ? DW + 4 : (tmo ? DW + 4 + TO : t + DW + 1);
    for (int e = 0; e < MAXE; e++) begin
      mosi_a[e] = 1'($urandom);
      txv_a[e]  = 1'($urandom);
      if (e == 1) mosi_a[e] = cmd;
      else if (e >= 2 && e <= FW + 1) mosi_a[e] = pay[FW-1-(e-2)];
      if (kind == 2 && e >= DW + 5) begin
        if (tmo ? (e <= DW + 4 + TO) : (e < t)) txv_a[e] = 1'b0;
        else if (!tmo && e == t) txv_a[e] = 1'b1;
      end
      b_rxv  = (e == DW + 4) && (e < n);
      b_err  = ((e == n) && (n <= done_e)) || ((kind == 2) && tmo && (e == done_e) && (e < n));
      b_miso = 1'b0;
      if (kind == 2 && !tmo && e > t && e <= t + DW && e < n) b_miso = txd[DW-(e-t)];
      exp_v[e] = {b_rxv, b_err, b_miso, (e < n)};
    end
    if (n > done_e) begin
      if (kind == 1) m_seen = 1'b1;
      if (kind == 2) m_seen = 1'b0;
    end
    m_tcap  = (kind == 2 && !tmo) ? t : -1;
    m_n     = n;
    exp_rxd = pay;
    exp_txd = txd;
    $display("frame kind=%0d cmd=%0d pay=%h ss_low_edges=%0d tx_delay=%0d tx_data=%h", kind, cmd, pay, n, d, txd);
  endtask

  task automatic drive_frame();
    for (int e = 0; e <= m_n; e++) begin
      ss_n     = (e == m_n);
      mosi     = mosi_a[e];
      tx_valid = txv_a[e];
      tx_data  = (e == m_tcap) ? exp_txd : DW'($urandom);
      @(posedge clk);
      @(negedge clk);
      obs_v[e]   = {rx_valid, frame_err, miso, busy};
      obs_rxd[e] = rx_data;
    end
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;
    ss_n_w = 1'b1; mosi_w = 1'b0; tx_valid_w = 1'b0; tx_data_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rx_data, rx_valid, miso, frame_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: outputs %h, expected 0", {rx_data, rx_valid, miso, frame_err, busy});
    end
    n_checks++;
    if ({rx_data_w, rx_valid_w, miso_w, frame_err_w, busy_w} !== '0) begin
      n_fail++;
      $display("FAIL reset_state_wide: outputs %h, expected 0", {rx_data_w, rx_valid_w, miso_w, frame_err_w, busy_w});
    end
    rst    = 1'b0;
    m_seen = 1'b0;
    plan_frame(1'b0, '1, 20, 0, '0);
    for (int e = 0; e <= 6; e++) begin
      ss_n = 1'b0;
      mosi = mosi_a[e];
      rst  = (e == 6);
      @(posedge clk);
      @(negedge clk);
      if (e == 5) begin
        n_checks++;
        if ({rx_data, rx_valid, frame_err, miso, busy} !== {10'h3C0, 4'b0001}) begin
          n_fail++;
          $display("FAIL partial_write edge 5: %h, expected %h", {rx_data, rx_valid, frame_err, miso, busy}, {10'h3C0, 4'b0001});
        end
      end
    end
    n_checks++;
    if ({rx_data, rx_valid, miso, frame_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_write_reset: outputs %h, expected 0", {rx_data, rx_valid, miso, frame_err, busy});
    end
    rst  = 1'b0;
    ss_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({rx_data, rx_valid, miso, frame_err, busy} !== '0) begin
      n_fail++;
      $display("FAIL after_reset_idle: outputs %h, expected 0", {rx_data, rx_valid, miso, frame_err, busy});
    end
    $display("reset sequence done");
  endtask

  task automatic test_write();
    logic [FW-1:0] pays[3];
    int            lens[3];
    pays = '{10'h0A5, FW'($urandom), FW'($urandom)};
    lens = '{15, 13, 20};
    for (int f = 0; f < 3; f++) begin
      plan_frame(1'b0, pays[f], lens[f], 0, '0);
      drive_frame();
      for (int e = 0; e <= m_n; e++) begin
        n_checks++;
        if (obs_v[e] !== exp_v[e]) begin
          n_fail++;
          $display("FAIL write f%0d edge %0d: {rx_valid,frame_err,MISO,busy}=%b, expected %b", f, e, obs_v[e], exp_v[e]);
        end
        if (exp_v[e][3]) begin
          n_checks++;
          if (obs_rxd[e] !== exp_rxd) begin
            n_fail++;
            $display("FAIL write f%0d rx_data: %h, expected %h", f, obs_rxd[e], exp_rxd);
          end
        end
      end
    end
  endtask

  task automatic test_read();
    logic [FW-1:0] pays[3];
    int            lens[3];
    logic [DW-1:0] txds[3];
    pays = '{10'h233, FW'($urandom), FW'($urandom)};
    lens = '{16, 2 * DW + 7, 16};
    txds = '{8'h00, 8'hC3, DW'($urandom)};
    for (int f = 0; f < 3; f++) begin
      plan_frame(1'b1, pays[f], lens[f], 0, txds[f]);
      drive_frame();
      for (int e = 0; e <= m_n; e++) begin
        n_checks++;
        if (obs_v[e] !== exp_v[e]) begin
          n_fail++;
          $display("FAIL read f%0d edge %0d: {rx_valid,frame_err,MISO,busy}=%b, expected %b", f, e, obs_v[e], exp_v[e]);
        end
        if (exp_v[e][3]) begin
          n_checks++;
          if (obs_rxd[e] !== exp_rxd) begin
            n_fail++;
            $display("FAIL read f%0d rx_data: %h, expected %h", f, obs_rxd[e], exp_rxd);
          end
        end
      end
    end
  endtask

  task automatic test_timeout();
    int lens[3];
    int ds[3];
    lens = '{16, DW + TO + 7, 16};
    ds   = '{0, TO, 0};
    for (int f = 0; f < 3; f++) begin
      plan_frame(1'b1, FW'($urandom), lens[f], ds[f], DW'($urandom));
      drive_frame();
      for (int e = 0; e <= m_n; e++) begin
        n_checks++;
        if (obs_v[e] !== exp_v[e]) begin
          n_fail++;
          $display("FAIL timeout f%0d edge %0d: {rx_valid,frame_err,MISO,busy}=%b, expected %b", f, e, obs_v[e], exp_v[e]);
        end
        if (exp_v[e][3]) begin
          n_checks++;
          if (obs_rxd[e] !== exp_rxd) begin
            n_fail++;
            $display("FAIL timeout f%0d rx_data: %h, expected %h", f, obs_rxd[e], exp_rxd);
          end
        end
      end
    end
  endtask

  task automatic test_abort();
    bit cmds[8];
    int lens[8];
    int ds[8];
    cmds = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    lens = '{7, 13, 12, 1, 40, 16, 18, 40};
    ds   = '{0, 0, 0, 0, 0, 0, 2, int'($urandom_range(0, 5))};
    for (int f = 0; f < 8; f++) begin
      plan_frame(cmds[f], FW'($urandom), lens[f], ds[f], DW'($urandom));
      drive_frame();
      for (int e = 0; e <= m_n; e++) begin
        n_checks++;
        if (obs_v[e] !== exp_v[e]) begin
          n_fail++;
          $display("FAIL abort f%0d edge %0d: {rx_valid,frame_err,MISO,busy}=%b, expected %b", f, e, obs_v[e], exp_v[e]);
        end
        if (exp_v[e][3]) begin
          n_checks++;
          if (obs_rxd[e] !== exp_rxd) begin
            n_fail++;
            $display("FAIL abort f%0d rx_data: %h, expected %h", f, obs_rxd[e], exp_rxd);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 25; f++) begin
      plan_frame(1'($urandom), FW'($urandom), int'($urandom_range(1, 40)),
                 int'($urandom_range(0, TO + 2)), DW'($urandom));
      drive_frame();
      for (int e = 0; e <= m_n; e++) begin
        n_checks++;
        if (obs_v[e] !== exp_v[e]) begin
          n_fail++;
          $display("FAIL b2b f%0d edge %0d: {rx_valid,frame_err,MISO,busy}=%b, expected %b", f, e, obs_v[e], exp_v[e]);
        end
        if (exp_v[e][3]) begin
          n_checks++;
          if (obs_rxd[e] !== exp_rxd) begin
            n_fail++;
            $display("FAIL b2b f%0d rx_data: %h, expected %h", f, obs_rxd[e], exp_rxd);
          end
        end
      end
    end
  endtask

  task automatic test_wide();
    logic [FW2-1:0] wp[2];
    logic [3:0]     exp4;
    wp = '{14'h2ABC, FW2'($urandom)};
    for (int f = 0; f < 2; f++) begin
      $display("wide write frame pay=%h", wp[f]);
      for (int e = 0; e <= DW2 + 5; e++) begin
        ss_n_w = (e == DW2 + 5);
        if (e == 1) mosi_w = 1'b0;
        else if (e >= 2 && e <= FW2 + 1) mosi_w = wp[f][FW2-1-(e-2)];
        else mosi_w = 1'($urandom);
        tx_valid_w = 1'($urandom);
        tx_data_w  = DW2'($urandom);
        @(posedge clk);
        @(negedge clk);
        exp4 = {(e == DW2 + 4), 1'b0, 1'b0, (e < DW2 + 5)};
        n_checks++;
        if ({rx_valid_w, frame_err_w, miso_w, busy_w} !== exp4) begin
          n_fail++;
          $display("FAIL wide f%0d edge %0d: {rx_valid,frame_err,MISO,busy}=%b, expected %b", f, e, {rx_valid_w, frame_err_w, miso_w, busy_w}, exp4);
        end
        if (e == DW2 + 4) begin
          n_checks++;
          if (rx_data_w !== wp[f]) begin
            n_fail++;
            $display("FAIL wide f%0d rx_data: %h, expected %h", f, rx_data_w, wp[f]);
          end
        end
      end
      ss_n_w = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
